sram_read_arbiter: RTL
======================

// Module: sram_read_arbiter
// PURPOSE
//  Shares the single async SRAM (read-only use) between two requesters: port 0 = audio sample
//  streamer, port 1 = chart/note-data reader. Accepts one word read at a time, sequences
//  CE/OE/address for READ_CYCLES clocks, latches SRAM data and returns it to the owning port.
//  Sits between the playback/chart logic and the top-level SRAM pins; WE_N is tied inactive.
// PARAMETERS
//  ADDR_W       20  SRAM word-address width
//  DATA_W       16  SRAM data width
//  READ_CYCLES  2   clocks OE_N held low per read (legal range 1..15)
// PORTS
//  Clk          in   1       system clock, all state on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  req          in   2       per-port read request; held high until that port's rd_valid
//  req_addr     in   2xADDR_W per-port word address, stable while req high
//  grant        out  2       one-cycle pulse: port's request accepted, addr captured
//  rd_valid     out  2       one-cycle pulse: rd_data holds that port's word
//  rd_data      out  DATA_W  shared read-data register
//  busy         out  1       high from grant cycle through rd_valid cycle
//  SRAM_ADDR    out  ADDR_W  SRAM address
//  SRAM_DQ      in   DATA_W  SRAM data (top level keeps pins tri-stated)
//  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out 1 each, active-low strobes
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, last_served=1 (port 0 wins first tie),
//   grant=0, rd_valid=0, rd_data=0, busy=0, SRAM_ADDR=0, CE_N=OE_N=WE_N=UB_N=LB_N=1.
//  FSM states IDLE, READ, RESP:
//   IDLE: strobes inactive. If any req: pick winner, register addr into SRAM_ADDR, owner<=winner,
//    pulse grant[winner] (registered, asserted in first READ cycle), wait_cnt<=0, go READ.
//   READ: CE_N=OE_N=UB_N=LB_N=0, SRAM_ADDR stable. wait_cnt increments each clock; on
//    wait_cnt==READ_CYCLES-1 capture SRAM_DQ into rd_data, go RESP.
//   RESP: strobes inactive; rd_valid[owner]=1 for exactly this cycle; last_served<=owner; go IDLE.
//  Latency: req sampled high in IDLE at edge t -> grant high cycle t+1 -> rd_valid high cycle
//   t+READ_CYCLES+1. Throughput: one word per READ_CYCLES+2 clocks; IDLE always lasts >=1 cycle.
//  Arbitration: only one req -> that port. Both -> port != last_served (round robin).
//   A continuously requesting port never waits more than one transaction.
//  Handshake rules:
//   - req dropped before grant: no transaction, no pulses.
//   - req dropped after grant: transaction completes, rd_valid still pulses (requester ignores).
//   - req_addr changes after grant: no effect (address registered at grant).
//   - req high again in RESP cycle: not sampled until IDLE next cycle.
//   - rd_data holds last word until next capture; never cleared except by reset.
//  Outputs all registered; SRAM_WE_N constant 1 after reset; grant and rd_valid never both high.
//  wait_cnt width 4 bits; no wrap (exits at READ_CYCLES-1).
//  Reset mid-READ: strobes deassert asynchronously, transaction dropped, no rd_valid; requesters
//   must re-issue after reset release.
// STRUCTURE
//  Package sram_arb_pkg: typedef enum logic [1:0] {IDLE, READ, RESP} arb_state_t;
//   localparams REQ_AUDIO=0, REQ_CHART=1, NUM_REQ=2.
//  Sub-module rr_arbiter2: combinational winner from req[1:0] and last_served; pure function,
//   no state. FSM, address/data registers and wait counter stay in sram_read_arbiter.
// TESTING (READ_CYCLES=2 unless stated; SRAM model returns addr[15:0]^16'hA5A5 combinationally)
//  1 Reset: reset_n=0 mid-sim -> all strobes 1, grant/rd_valid/busy 0 same cycle, rd_data=0.
//  2 Single port0 read addr 0x00010 -> grant[0] at t+1, OE_N low 2 cycles,
//    rd_valid[0] at t+3 with rd_data=0xA5B5, SRAM_ADDR=0x00010 during READ.
//  3 Both req held high continuously, addrs 0x1/0x2 -> grants alternate 0,1,0,1; each port
//    receives its own data; 8 reads complete in 32 cycles.
//  4 Port1 drops req after grant -> rd_valid[1] still pulses; drop before grant -> no grant.
//  5 reset_n asserted in second READ cycle -> OE_N=1 immediately, no rd_valid; after
//    release, re-issued req completes normally with port 0 winning the tie.
//  6 READ_CYCLES=5 -> OE_N low exactly 5 cycles, rd_valid at t+6.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM read arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Requester indices: audio streamer on port 0, chart reader on port 1.
  localparam int REQ_AUDIO = 0;
  localparam int REQ_CHART = 1;
  localparam int NUM_REQ   = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the port
// that was not served last wins. Purely combinational, holds no state.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       winner,
  output logic       any
);

  // Winner selection from the request pair and the previous owner.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    any    = |req;
    winner = 1'b0;
    if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b11) begin
      winner = ~last_served;
    end
  end

endmodule

// File: rtl/sram_read_arbiter.sv
// Shares one asynchronous SRAM (read-only) between the audio streamer (port 0)
// and the chart reader (port 1). One word read at a time: the winning address
// is registered onto the pins, CE/OE/UB/LB are held low for READ_CYCLES clocks,
// the data bus is captured and handed back to the owning port with a pulse.
module sram_read_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int READ_CYCLES = 2
) (
  input  logic                      Clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         SRAM_ADDR,
  input  logic [DATA_W-1:0]         SRAM_DQ,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N,
  output logic                      SRAM_WE_N,
  output logic                      SRAM_UB_N,
  output logic                      SRAM_LB_N
);

  // Last READ cycle index; the counter never passes it, so 4 bits cover 1..15.
  localparam logic [3:0] LAST_WAIT = 4'(READ_CYCLES - 1);

  arb_state_t          state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;
  logic [NUM_REQ-1:0]  grant_d, valid_d;
  logic                strobe_n_q;
  logic                win;
  logic                any_req;

  rr_arbiter2 u_rr (
    .req         (req),
    .last_served (last_q),
    .winner      (win),
    .any         (any_req)
  );

  // Next-state and next-output decode for the IDLE -> READ -> RESP sequence.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = SRAM_ADDR;
    data_d  = rd_data;
    grant_d = '0;
    valid_d = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          addr_d  = win ? req_addr[REQ_CHART*ADDR_W +: ADDR_W]
                        : req_addr[REQ_AUDIO*ADDR_W +: ADDR_W];
          owner_d = win;
          grant_d[win] = 1'b1;
          wait_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == LAST_WAIT) begin
          data_d           = SRAM_DQ;
          valid_d[owner_q] = 1'b1;
          state_d          = RESP;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bookkeeping and registered outputs; strobes follow the next state
  // so they are low for exactly the READ cycles and rise asynchronously on reset.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      SRAM_ADDR  <= '0;
      rd_data    <= '0;
      grant      <= '0;
      rd_valid   <= '0;
      busy       <= 1'b0;
      strobe_n_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      wait_q     <= wait_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      SRAM_ADDR  <= addr_d;
      rd_data    <= data_d;
      grant      <= grant_d;
      rd_valid   <= valid_d;
      busy       <= (state_d != IDLE);
      strobe_n_q <= (state_d != READ);
    end
  end

  assign SRAM_CE_N = strobe_n_q;
  assign SRAM_OE_N = strobe_n_q;
  assign SRAM_UB_N = strobe_n_q;
  assign SRAM_LB_N = strobe_n_q;
  assign SRAM_WE_N = 1'b1;

endmodule
